// File: rtl/core_pkg.sv
// core_pkg: shared RV32I core constants
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch-side signals towards instruction memory and decode
interface inst_fetch_if import core_pkg::*; ();
  logic stall;
  logic redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_inst;
  logic if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  modport master (
    input stall, redirect, redirect_pc, mem_inst,
    output mem_addr, if_valid, if_pc, if_inst
  );
  modport slave (
    output stall, redirect, redirect_pc, mem_inst,
    input mem_addr, if_valid, if_pc, if_inst
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: RV32I fetch front end with one-cycle memory latency, stall hold buffer and redirect
module inst_fetch import core_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic clk_50,
  input logic rst,
  inst_fetch_if.master f
);
  logic [XLEN-1:0] pc_q, pend_pc, hold_pc, hold_inst;
  logic pend_valid, hold_valid, hold_vout;
  assign f.mem_addr = pc_q;
  assign f.if_valid = hold_valid ? hold_vout : pend_valid;
  assign f.if_pc = hold_valid ? hold_pc : pend_pc;
  assign f.if_inst = hold_valid ? hold_inst : pend_valid ? f.mem_inst : NOP_INST;
  // hold_vout keeps whether the snapshot was a real instruction or a bubble
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc <= '0;
      hold_valid <= 1'b0;
      hold_vout <= 1'b0;
      hold_pc <= '0;
      hold_inst <= NOP_INST;
    end else if (f.redirect) begin
      pc_q <= f.redirect_pc & ~XLEN'(3);
      pend_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else if (f.stall) begin
      if (!hold_valid) begin
        hold_valid <= 1'b1;
        hold_vout <= f.if_valid;
        hold_pc <= f.if_pc;
        hold_inst <= f.if_inst;
      end
    end else begin
      pend_pc <= pc_q;
      pend_valid <= 1'b1;
      pc_q <= pc_q + PC_STEP;
      hold_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed plus random stimulus against a presented-stream reference model
module tb_inst_fetch;
  import core_pkg::*;
  logic clk_50 = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mem_q;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_nxt, m_pc;
  logic m_v;
  inst_fetch_if bus();
  inst_fetch #(.RESET_PC(32'h0)) dut (.clk_50(clk_50), .rst(rst), .f(bus));
  always #10 clk_50 = ~clk_50;
  function automatic logic [31:0] img(input logic [31:0] a);
    case (a)
      32'h14: return 32'hff81_0113;
      32'h18: return 32'h0141_2223;
      32'h74: return 32'h0049_8993;
      32'h78: return 32'hfa00_08e3;
      default: return (a < 32'h14) ? NOP_INST : (a ^ 32'h6b5a_0000);
    endcase
  endfunction
  always @(posedge clk_50) mem_q <= img(bus.mem_addr);
  assign bus.mem_inst = mem_q;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  task automatic check_all();
    check("if_valid", {31'b0, bus.if_valid}, {31'b0, m_v});
    check("if_pc", bus.if_pc, m_pc);
    check("if_inst", bus.if_inst, m_v ? img(m_pc) : NOP_INST);
    check("mem_addr", bus.mem_addr, m_nxt);
  endtask
  task automatic model_reset();
    m_nxt = 32'h0;
    m_pc = 32'h0;
    m_v = 1'b0;
  endtask
  // The model tracks only what decode sees: the presented PC and the next PC to present
  task automatic cycle(input logic s, input logic r, input logic [31:0] t);
    bus.stall = s;
    bus.redirect = r;
    bus.redirect_pc = t;
    @(posedge clk_50);
    if (r) begin
      m_nxt = t & 32'hFFFF_FFFC;
      m_v = 1'b0;
    end else if (!s) begin
      m_v = 1'b1;
      m_pc = m_nxt;
      m_nxt = m_nxt + 32'd4;
    end
    @(negedge clk_50);
    check_all();
  endtask
  task automatic pulse_reset();
    #3 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk_50);
    check_all();
    rst = 1'b0;
  endtask
  initial begin
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    model_reset();
    @(negedge clk_50);
    @(negedge clk_50);
    check_all();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);
    check("plan_pc14", bus.if_pc, 32'h14);
    check("plan_inst14", bus.if_inst, 32'hff81_0113);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    check("plan_stall_inst", bus.if_inst, 32'hff81_0113);
    cycle(1'b0, 1'b0, 32'h0);
    check("plan_after_stall", bus.if_inst, 32'h0141_2223);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h74);
    cycle(1'b0, 1'b0, 32'h0);
    check("plan_redir_inst", bus.if_inst, 32'h0049_8993);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h74);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h76);
    check("plan_mask_addr", bus.mem_addr, 32'h74);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h18);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    pulse_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hFFFF_FFF4);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31)))
                                        : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, tgt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end for the pipelined RV32I core. Acts as the requester to the synchronous-read instruction memory: it drives the word address, accounts for the memory's one-cycle read latency, and presents a PC/instruction/valid triple to the decode stage. It also absorbs decode stalls with a one-entry hold buffer and handles branch redirects with a fixed one-bubble penalty.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk_50`, input, 1: the single core clock. Every register updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `stall`, input, 1: decode cannot accept; the current output must be held.
- `redirect`, input, 1: taken branch/jump resolved; flushes the fetch path.
- `redirect_pc`, input, 32: new fetch target. Bits [1:0] are ignored (forced to 0).
- `mem_addr`, output, 32: byte address to the instruction memory. Driven directly from the `pc_q` register.
- `mem_inst`, input, 32: memory data. It is valid in the cycle after the edge that sampled `mem_addr`.
- `if_valid`, output, 1: `if_pc` and `if_inst` hold a real instruction.
- `if_pc`, output, 32: PC of the presented instruction.
- `if_inst`, output, 32: presented instruction. It is 32'h0000_0013 (NOP) whenever `if_valid`=0.

## Operation
- Registers:
  - `pc_q`: next address to request.
  - `pend_valid`/`pend_pc`: the request issued at the last accepted edge. Its data is on `mem_inst` now.
  - `hold_valid`/`hold_pc`/`hold_inst`: snapshot of the output, taken while stalled.
- The memory samples `mem_addr` at every edge, including during stall and bubble cycles.
- Output selection:
  - If `hold_valid`=1, outputs come from the hold registers.
  - Otherwise `if_valid`=`pend_valid`, `if_pc`=`pend_pc`, and `if_inst`=`mem_inst` (NOP if not valid).
- Derived states:
  - EMPTY: `pend_valid`=0 and `hold_valid`=0.
  - RUN: `pend_valid`=1 and `hold_valid`=0.
  - HOLD: `hold_valid`=1.
- Edge update, in priority order:
  - `redirect`=1:
    - `pc_q` <= {`redirect_pc`[31:2],2'b00}; `pend_valid` <= 0; `hold_valid` <= 0. Go to EMPTY.
    - `stall` is ignored at this edge.
    - The memory word fetched at this edge is discarded.
  - `stall`=1:
    - `pc_q` and the pend registers are held.
    - If `hold_valid`=0, the hold registers capture the current output triple and `hold_valid` <= 1 (EMPTY/RUN -> HOLD).
    - If `hold_valid`=1, nothing changes.
  - Otherwise (accept):
    - `pend_pc` <= `pc_q`; `pend_valid` <= 1; `pc_q` <= `pc_q`+4; `hold_valid` <= 0. Go to RUN.
- Why HOLD is correct on release: during HOLD, `mem_inst` already carries the word at `pc_q`. On release that word becomes the pend data, so no instruction is lost or duplicated.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Unmapped addresses return 0 from memory. These are passed through as-is with `if_valid`=1; decode flags them as illegal.

## Timing
- Reset (asynchronous):
  - `pc_q`=`RESET_PC`, `pend_valid`=0, `hold_valid`=0, `pend_pc`=0, `hold_pc`=0, `hold_inst`=NOP.
  - Outputs during reset: `if_valid`=0, `if_pc`=0, `if_inst`=NOP, `mem_addr`=`RESET_PC`.
- Startup: the first valid output appears one cycle after the first accepted edge following reset release.
- Fetch-to-present latency: 1 cycle. Throughput is 1 instruction per cycle with no stalls.
- Redirect: exactly one bubble cycle (`if_valid`=0) after the redirect edge. The target instruction is presented in the cycle after the next accepted edge.
- A stall during a bubble is allowed and extends the bubble; the HOLD snapshot is taken with `if_valid`=0.
- Stall: outputs are bit-stable for the whole stall. The next instruction follows in the cycle after release.
- Reset asserted mid-stream: all in-flight and held words are dropped immediately, without waiting for an edge.

## Structure
- Shared core package `core_pkg`: `NOP_INST`=32'h0000_0013, `PC_STEP`=4, `XLEN`=32.
- Single module, no sub-modules. The hold buffer is small enough to stay inline.
- Target size: about 150 lines.

## Test plan
Program image: 0x00–0x10 are NOPs, 0x14=ff810113, 0x18=01412223, 0x74=00498993, 0x78=fa0008e3.

- Reset release with no stall -> cycle 1: `if_valid`=0. Cycle 2: `if_pc`=0, `if_inst`=00000013. Cycle 7: `if_pc`=0x14, `if_inst`=ff810113, with one instruction per cycle in between.
- `stall` held for 3 cycles while 0x14 is presented -> `if_inst` stays ff810113 for 4 cycles total. After release, 0x18 (01412223) is presented; 0x1C is not skipped.
- `redirect`=1 with `redirect_pc`=0x74 -> one cycle with `if_valid`=0, then 0x74/00498993, then 0x78/fa0008e3.
- `redirect` and `stall` at the same edge -> redirect wins: one bubble, then 0x74. No stale held word is ever presented.
- `redirect_pc`=0x76 -> `mem_addr`=0x74 and `if_pc`=0x74.
- `rst` pulsed mid-stall, in HOLD at 0x18 -> `if_valid`=0 immediately and `mem_addr`=`RESET_PC`. The sequence restarts from 0x00.
